// File: rtl/datapath_pkg.sv
// Shared constants for the 16-bit single-cycle datapath: widths, depths, field positions, ALU codes.
// No logic here beyond a pure sign-extension helper.
// Not applicable (no flow control).
package datapath_pkg;

  localparam int DW         = 16;   // data / instruction / PC width
  localparam int AW         = 8;    // memory address width
  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;
  localparam int NREGS      = 8;
  localparam int RW         = 3;    // register index width

  // Instruction field bit positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RS_HI  = 12;
  localparam int RS_LO  = 10;
  localparam int RT_HI  = 9;
  localparam int RT_LO  = 7;
  localparam int RD_HI  = 6;
  localparam int RD_LO  = 4;
  localparam int FN_HI  = 1;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 6;
  localparam int IMM_W  = 7;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_NOR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_fn_e;

  // Immediate is the low 7 bits of the instruction, sign-extended to DW
  function automatic logic [DW-1:0] sext_imm(input logic [DW-1:0] instr);
    return {{(DW-IMM_W){instr[IMM_HI]}}, instr[IMM_HI:0]};
  endfunction

endpackage

// File: rtl/datapath_imem.sv
// Instruction memory: 256 x 16 array read combinationally by address; contents loaded externally.
// Latency: combinational read, zero cycles.
// No backpressure; always returns the addressed word.
module datapath_imem
  import datapath_pkg::*;
(
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] instr_o
);

  logic [DW-1:0] mem [IMEM_DEPTH];

  assign instr_o = mem[addr_i];

endmodule

// File: rtl/datapath.sv
// Single-cycle 16-bit datapath: fetch, decode, ALU, data memory and write-back from the current PC.
// Latency: one instruction per clock; only PC, register file and data memory are state.
// No backpressure; control inputs are expected valid for the instruction currently addressed by PC.
module datapath
  import datapath_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       NIA,
  input  logic       RegDst,
  input  logic       RegWrite,
  input  logic       ALUSrc,
  input  logic [2:0] ALUFn,
  input  logic       MemWrite,
  input  logic       MemRead,
  input  logic       MemToReg,
  output logic [4:0] OpFn
);

  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] rf_q   [NREGS];
  logic [DW-1:0] dmem_q [DMEM_DEPTH];

  logic [DW-1:0] instr;
  logic [RW-1:0] rs_a, rt_a, rd_a, wr_a;
  logic [DW-1:0] imm;
  logic [DW-1:0] rs_dat, rt_dat, alu_b, alu_res;
  logic [DW-1:0] mem_rdat, wb_dat;
  logic          alubeq;

  datapath_imem IR (
    .addr_i (pc_q[AW-1:0]),
    .instr_o(instr)
  );

  assign rs_a = instr[RS_HI:RS_LO];
  assign rt_a = instr[RT_HI:RT_LO];
  assign rd_a = instr[RD_HI:RD_LO];
  assign imm  = sext_imm(instr);
  assign OpFn = {instr[OP_HI:OP_LO], instr[FN_HI:FN_LO]};

  // r0 is hard-wired to zero on both read ports
  assign rs_dat = (rs_a == '0) ? '0 : rf_q[rs_a];
  assign rt_dat = (rt_a == '0) ? '0 : rf_q[rt_a];
  assign alu_b  = ALUSrc ? imm : rt_dat;

  // ALU: all results wrap to 16 bits; slt compares as signed
  always_comb begin
    alu_res = '0;
    case (alu_fn_e'(ALUFn))
      ALU_ADD:  alu_res = rs_dat + alu_b;
      ALU_SUB:  alu_res = rs_dat - alu_b;
      ALU_AND:  alu_res = rs_dat & alu_b;
      ALU_OR:   alu_res = rs_dat | alu_b;
      ALU_XOR:  alu_res = rs_dat ^ alu_b;
      ALU_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(rs_dat) < $signed(alu_b))};
      ALU_NOR:  alu_res = ~(rs_dat | alu_b);
      ALU_PASS: alu_res = alu_b;
      default:  alu_res = '0;
    endcase
  end

  assign alubeq   = (alu_res == '0);
  assign mem_rdat = MemRead ? dmem_q[alu_res[AW-1:0]] : '0;
  assign wb_dat   = MemToReg ? mem_rdat : alu_res;
  assign wr_a     = RegDst ? rd_a : rt_a;

  // Next PC: relative branch when the branch select is set and the ALU result is zero
  always_comb begin
    pc_d = pc_q + 16'd1;
    if (NIA && alubeq) begin
      pc_d = pc_q + 16'd1 + imm;
    end
  end

  // PC register, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Register file: cleared by reset, writes to r0 dropped, reads this cycle see the old value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (RegWrite && (wr_a != '0)) begin
      rf_q[wr_a] <= wb_dat;
    end
  end

  // Data memory: contents survive reset, but no store happens while reset is asserted
  always_ff @(posedge clk or negedge rst) begin
    if (rst) begin
      if (MemWrite) begin
        dmem_q[alu_res[AW-1:0]] <= rt_dat;
      end
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the single-cycle datapath with a scoreboard of expected architectural state.
// Expectations are queued before each clock and compared one time unit after the edge.
// Control inputs are driven per instruction, exactly as an external control block would.
module tb_datapath;
  import datapath_pkg::*;

  logic       clk;
  logic       rst;
  logic       NIA, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg;
  logic [2:0] ALUFn;
  logic [4:0] OpFn;

  int checks   = 0;
  int failures = 0;

  localparam int K_PC   = 0;
  localparam int K_REG  = 1;
  localparam int K_DMEM = 2;
  localparam int K_OPFN = 3;
  localparam int K_BEQ  = 4;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];

  logic [2:0]  fn_tab  [8];
  logic [15:0] exp_tab [8];
  logic [15:0] model_r5;

  datapath d (
    .clk     (clk),
    .rst     (rst),
    .NIA     (NIA),
    .RegDst  (RegDst),
    .RegWrite(RegWrite),
    .ALUSrc  (ALUSrc),
    .ALUFn   (ALUFn),
    .MemWrite(MemWrite),
    .MemRead (MemRead),
    .MemToReg(MemToReg),
    .OpFn    (OpFn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ri(input logic [2:0] rs, input logic [2:0] rt, input logic [6:0] imm);
    return {3'b000, rs, rt, imm};
  endfunction

  function automatic logic [15:0] rr(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
    return {3'b000, rs, rt, rd, 4'b0000};
  endfunction

  function automatic logic [15:0] observe(input int kind, input int idx);
    logic [15:0] v;
    logic [2:0]  ri3;
    logic [7:0]  ai8;
    ri3 = idx[2:0];
    ai8 = idx[7:0];
    v = 16'hDEAD;
    case (kind)
      K_PC:   v = d.pc_q;
      K_REG:  v = d.rf_q[ri3];
      K_DMEM: v = d.dmem_q[ai8];
      K_OPFN: v = {11'b0, OpFn};
      K_BEQ:  v = {15'b0, d.alubeq};
      default: v = 16'hDEAD;
    endcase
    return v;
  endfunction

  task automatic expect_v(input string tag, input int kind, input int idx, input logic [15:0] v);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t         e;
    logic [15:0] o;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = observe(e.kind, e.idx);
      checks++;
      assert (o === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic ctl(input logic nia, input logic regdst, input logic regwrite, input logic alusrc,
                     input logic [2:0] fn, input logic memwrite, input logic memread, input logic memtoreg);
    NIA      = nia;
    RegDst   = regdst;
    RegWrite = regwrite;
    ALUSrc   = alusrc;
    ALUFn    = fn;
    MemWrite = memwrite;
    MemRead  = memread;
    MemToReg = memtoreg;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ctl(0, 0, 0, 0, ALU_ADD, 0, 0, 0);

    // Program for the first run
    d.IR.mem[0]  = 16'b0001100010011001;
    d.IR.mem[1]  = ri(0, 1, 7'd5);
    d.IR.mem[2]  = ri(0, 2, 7'd3);
    d.IR.mem[3]  = ri(1, 2, 7'd2);
    d.IR.mem[4]  = rr(1, 2, 3);
    d.IR.mem[5]  = rr(1, 2, 3);
    d.IR.mem[6]  = ri(1, 4, 7'h7F);
    d.IR.mem[7]  = ri(0, 5, 7'h56);
    for (int i = 8; i <= 16; i++) d.IR.mem[i] = rr(5, 5, 5);
    d.IR.mem[17] = ri(5, 5, 7'h4D);
    d.IR.mem[18] = ri(0, 5, 7'd4);
    d.IR.mem[19] = ri(0, 6, 7'd4);
    d.IR.mem[20] = rr(1, 2, 7);
    d.IR.mem[21] = rr(1, 2, 7);
    d.IR.mem[22] = rr(1, 2, 7);
    d.IR.mem[23] = rr(2, 1, 7);
    d.IR.mem[24] = rr(5, 1, 7);
    d.IR.mem[25] = rr(1, 5, 7);
    d.IR.mem[26] = rr(1, 2, 7);
    d.IR.mem[27] = rr(1, 2, 7);
    d.IR.mem[28] = ri(0, 7, 7'd4);
    d.IR.mem[29] = ri(0, 0, 7'd5);
    d.IR.mem[30] = ri(0, 2, 7'd10);

    fn_tab  = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLT, ALU_SLT, ALU_NOR, ALU_PASS};
    exp_tab = '{16'h0001, 16'h0007, 16'h0006, 16'h0001, 16'h0001, 16'h0000, 16'hFFF8, 16'h0003};

    // Reset state
    #1;
    expect_v("rst_pc", K_PC, 0, 16'h0000);
    expect_v("rst_opfn", K_OPFN, 0, 16'h0001);
    for (int i = 0; i < 8; i++) expect_v($sformatf("rst_r%0d", i), K_REG, i, 16'h0000);
    drain();

    #9 rst = 1'b1;
    #1;
    expect_v("rel_opfn", K_OPFN, 0, 16'h0001);
    expect_v("rel_pc", K_PC, 0, 16'h0000);
    drain();

    expect_v("pc_1", K_PC, 0, 16'd1);
    step();

    ctl(0, 0, 1, 1, ALU_ADD, 0, 0, 0);
    expect_v("addi_r1", K_REG, 1, 16'd5);
    expect_v("pc_2", K_PC, 0, 16'd2);
    step();

    expect_v("addi_r2", K_REG, 2, 16'd3);
    expect_v("pc_3", K_PC, 0, 16'd3);
    step();

    ctl(1, 0, 0, 0, ALU_SUB, 0, 0, 0);
    #1;
    expect_v("beq_nt_flag", K_BEQ, 0, 16'd0);
    drain();
    expect_v("beq_nt_pc", K_PC, 0, 16'd4);
    step();

    ctl(0, 1, 1, 0, ALU_ADD, 0, 0, 0);
    expect_v("add_r3", K_REG, 3, 16'd8);
    step();

    ctl(0, 1, 1, 0, ALU_SUB, 0, 0, 0);
    expect_v("sub_r3", K_REG, 3, 16'd2);
    step();

    ctl(0, 0, 1, 1, ALU_ADD, 0, 0, 0);
    expect_v("imm_neg1_r4", K_REG, 4, 16'd4);
    step();

    model_r5 = 16'hFFD6;
    expect_v("addi_r5", K_REG, 5, model_r5);
    step();

    ctl(0, 1, 1, 0, ALU_ADD, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      model_r5 = model_r5 + model_r5;
      expect_v($sformatf("dbl_r5_%0d", i), K_REG, 5, model_r5);
      step();
    end

    ctl(0, 0, 1, 1, ALU_ADD, 0, 0, 0);
    expect_v("build_r5", K_REG, 5, 16'hABCD);
    step();

    ctl(0, 0, 0, 1, ALU_ADD, 1, 0, 0);
    expect_v("sw_dmem4", K_DMEM, 4, 16'hABCD);
    step();

    ctl(0, 0, 1, 1, ALU_ADD, 0, 1, 1);
    expect_v("lw_r6", K_REG, 6, 16'hABCD);
    step();

    for (int i = 0; i < 8; i++) begin
      ctl(0, 1, 1, 0, fn_tab[i], 0, 0, 0);
      expect_v($sformatf("alu_fn%0d_case%0d", fn_tab[i], i), K_REG, 7, exp_tab[i]);
      step();
    end

    ctl(0, 0, 1, 1, ALU_ADD, 0, 0, 1);
    expect_v("noread_zero_r7", K_REG, 7, 16'h0000);
    step();

    ctl(0, 0, 1, 1, ALU_ADD, 0, 0, 0);
    expect_v("r0_write_a", K_REG, 0, 16'h0000);
    step();

    ctl(0, 0, 1, 1, ALU_ADD, 1, 0, 0);
    expect_v("sw_rw_dmem10", K_DMEM, 10, 16'd3);
    expect_v("sw_rw_r2", K_REG, 2, 16'd10);
    expect_v("pc_31", K_PC, 0, 16'd31);
    step();

    // Second run: reprogram, then asynchronous reset
    d.IR.mem[0] = ri(0, 0, 7'd5);
    d.IR.mem[3] = ri(1, 1, 7'd2);
    d.IR.mem[5] = ri(0, 2, 7'd4);
    d.IR.mem[6] = ri(1, 1, 7'h7E);
    rst = 1'b0;
    #1;
    expect_v("arst_pc", K_PC, 0, 16'h0000);
    for (int i = 1; i < 8; i++) expect_v($sformatf("arst_r%0d", i), K_REG, i, 16'h0000);
    drain();
    #1 rst = 1'b1;

    ctl(0, 0, 1, 1, ALU_ADD, 0, 0, 0);
    expect_v("r0_write_b", K_REG, 0, 16'h0000);
    expect_v("b_pc_1", K_PC, 0, 16'd1);
    step();
    expect_v("b_r1", K_REG, 1, 16'd5);
    step();
    expect_v("b_r2", K_REG, 2, 16'd3);
    step();

    ctl(1, 0, 0, 0, ALU_SUB, 0, 0, 0);
    #1;
    expect_v("beq_t_flag", K_BEQ, 0, 16'd1);
    drain();
    expect_v("beq_t_pc", K_PC, 0, 16'd6);
    step();

    #1;
    expect_v("beq_back_flag", K_BEQ, 0, 16'd1);
    drain();
    expect_v("beq_back_pc", K_PC, 0, 16'd5);
    step();

    // Mid-instruction reset at PC=5: the pending store and register write must be dropped
    ctl(0, 0, 1, 1, ALU_ADD, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    expect_v("mid_pc", K_PC, 0, 16'h0000);
    expect_v("mid_r1", K_REG, 1, 16'h0000);
    expect_v("mid_r2", K_REG, 2, 16'h0000);
    drain();
    expect_v("mid_dmem4", K_DMEM, 4, 16'hABCD);
    expect_v("mid_r2_hold", K_REG, 2, 16'h0000);
    expect_v("mid_pc_hold", K_PC, 0, 16'h0000);
    step();

    // PC wrap: branch back from 0 to 16'hFFFF, then increment to 0
    d.IR.mem[0]   = ri(0, 0, 7'h7E);
    d.IR.mem[255] = 16'hE003;
    #1 rst = 1'b1;
    ctl(1, 0, 0, 0, ALU_SUB, 0, 0, 0);
    #1;
    expect_v("wrap_flag", K_BEQ, 0, 16'd1);
    drain();
    expect_v("wrap_pc_ffff", K_PC, 0, 16'hFFFF);
    step();
    expect_v("wrap_opfn", K_OPFN, 0, 16'h001F);
    drain();
    ctl(0, 0, 0, 0, ALU_ADD, 0, 0, 0);
    expect_v("wrap_pc_0", K_PC, 0, 16'h0000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset (the port keeps the codebase name rst despite active-low polarity).
REQ-002 SHALL have port: NIA  input  1  next-instruction-address select; 1 = branch instruction.
REQ-003 SHALL have port: RegDst  input  1  write-register select; 1 = rd, 0 = rt.
REQ-004 SHALL have port: RegWrite  input  1  register-file write enable.
REQ-005 SHALL have port: ALUSrc  input  1  ALU B select; 1 = sign-extended immediate, 0 = rt data.
REQ-006 SHALL have port: ALUFn  input  3  ALU operation code.
REQ-007 SHALL have ports: MemWrite  input  1  data-memory write enable; MemRead  input  1  data-memory read enable.
REQ-008 SHALL have port: MemToReg  input  1  write-back select; 1 = memory data, 0 = ALU result.
REQ-009 SHALL have port: OpFn  output  5  {instr[15:13], instr[1:0]} of the current instruction, driven combinationally to the external control block.

Function
REQ-010 SHALL use 16-bit instructions: op[15:13], rs[12:10], rt[9:7], rd[6:4], spare[3:2], fn[1:0]; imm = instr[6:0] sign-extended to 16 bits.
REQ-011 SHALL execute single-cycle: fetch, decode, ALU, memory and write-back are combinational from PC; only PC, register file and data memory update, on posedge clk.
REQ-012 SHALL fetch from instruction memory indexed by PC[7:0]; PC is 16 bits and wraps 16'hFFFF -> 0.
REQ-013 SHALL provide register file of 8 x 16 bits, two combinational read ports (rs, rt); r0 reads 0 and ignores writes.
REQ-014 SHALL apply ALUFn: 000 add, 001 sub (A-B), 010 and, 011 or, 100 xor, 101 slt signed (1/0), 110 nor, 111 pass B; results mod 2^16, no flags except zero.
REQ-015 SHALL drive internal signal alubeq = 1 when ALU result == 0.
REQ-016 SHALL compute next PC = PC+1+imm when NIA && alubeq, else PC+1.
REQ-017 SHALL, when RegWrite=1, write the register chosen by RegDst with MemToReg-selected data at posedge; same-cycle reads return the old value.
REQ-018 SHALL, when MemWrite=1, write rt data into data memory at address ALU result[7:0]; read data = mem[ALU result[7:0]] when MemRead=1, else 0.
REQ-019 SHALL give precedence to reset: MemWrite and MemRead both 1 perform both; MemWrite and RegWrite both 1 perform both.

Reset
REQ-020 SHALL, while rst=0, force PC=0 and all registers=0 immediately (asynchronous); data and instruction memories are not cleared.
REQ-021 SHALL, after rst rises, execute mem[0] at the first posedge; OpFn reflects instr mem[0] during reset.
REQ-022 SHALL handle mid-operation reset by discarding the in-flight instruction with no register or memory write.

Structure
REQ-023 SHALL hold ALUFn encodings, field bit positions, 16-bit width and 256-word depths as constants in a shared package.
REQ-024 SHALL place instruction memory in a sub-module instance named IR containing a 256 x 16 array named mem, writable hierarchically by benches (d.IR.mem[i]); no other sub-module is required.

Verification
REQ-025 SHALL cover: rst=0 at t=0, released at 10 ns, mem[0]=16'b0001100010011001 -> OpFn=00001 during and after reset, PC advances 0,1,2,3 on successive posedges.
REQ-026 SHALL cover: r1=5, r2=3, RegDst=1, RegWrite=1, ALUFn=000 with rs=1, rt=2, rd=3 -> r3=8 after one posedge; ALUFn=001 -> r3=2.
REQ-027 SHALL cover: ALUSrc=1, imm=7'h7F -> B=16'hFFFF; add with rs=r1=5 -> 4.
REQ-028 SHALL cover: MemWrite=1, address 4, rt=16'hABCD, then MemRead=1, MemToReg=1 at address 4 -> destination register = 16'hABCD.
REQ-029 SHALL cover: NIA=1, ALUFn=001, rs=rt (equal values), imm=2 at PC=3 -> alubeq=1, next PC=6; with rs!=rt -> PC=4.
REQ-030 SHALL cover: rst pulsed low mid-program at PC=5 -> PC=0 immediately, registers 0, r0 write attempt leaves r0=0.
